// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the IF/ID payload type.
// Vector constants here are used by if_stage (IRQ vector only in IF_STAGE_IRQ_EN builds).
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
   localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
   localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
   localparam logic [1:0] PC_SEL_JR     = 2'd3;

   localparam logic [XLEN-1:0] NOP_WORD   = 32'h0000_0000;
   localparam logic [XLEN-1:0] RESET_VEC  = 32'h8000_0000;
   localparam logic [XLEN-1:0] IRQ_VECTOR = 32'h8000_0004;
   localparam logic [XLEN-1:0] PC_STEP    = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{instr: NOP_WORD, pc_plus4: '0, valid: 1'b0};

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select for sequential, branch, jump and register-jump fetch.
module pc_next_mux
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      pc_sel,
   input  logic            stall,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jump_target,
   input  logic [XLEN-1:0] jr_target,
   output logic [XLEN-1:0] pc_next_c,
   output logic            redirect_c
);

   // Branch and jump keep the current supervisor bit; register jump may change it.
   always_comb begin
      pc_next_c  = pc + PC_STEP;
      redirect_c = (pc_sel != PC_SEL_SEQ);
      case (pc_sel)
         PC_SEL_BRANCH: pc_next_c = {pc[XLEN-1], branch_target[XLEN-2:2], 2'b00};
         PC_SEL_JUMP:   pc_next_c = {pc[XLEN-1], jump_target[XLEN-2:2], 2'b00};
         PC_SEL_JR:     pc_next_c = word_align(jr_target);
         default:       if (stall) pc_next_c = pc;
      endcase
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Optional interrupt entry enabled by defining IF_STAGE_IRQ_EN.
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_VEC
`ifdef IF_STAGE_IRQ_EN
   ,
   parameter logic [XLEN-1:0] IRQ_VEC  = IRQ_VECTOR
`endif
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic [1:0]      pc_sel,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jump_target,
   input  logic [XLEN-1:0] jr_target,
`ifdef IF_STAGE_IRQ_EN
   input  logic            irq,
   output logic [XLEN-1:0] epc,
   output logic            epc_we,
`endif
   output logic [XLEN-1:0] rom_addr,
   input  logic [XLEN-1:0] rom_data,
   output logic [XLEN-1:0] ifid_instr,
   output logic [XLEN-1:0] ifid_pc_plus4,
   output logic            ifid_valid
);

   logic [XLEN-1:0] pc_q, pc_d, pc_next_c;
   logic            redirect_c;
   ifid_t           ifid_q, ifid_d;

   pc_next_mux u_pc_next_mux (
      .pc            (pc_q),
      .pc_sel        (pc_sel),
      .stall         (stall),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .jr_target     (jr_target),
      .pc_next_c     (pc_next_c),
      .redirect_c    (redirect_c)
   );

`ifdef IF_STAGE_IRQ_EN
   logic [XLEN-1:0] epc_q, epc_d;
   logic            epc_we_q, epc_we_d;
   logic            irq_take_c;
`endif

   always_comb begin
      pc_d   = pc_next_c;
      ifid_d = ifid_q;
      if (redirect_c || flush) begin
         ifid_d = IFID_BUBBLE;
      end else if (!stall) begin
         ifid_d = '{instr: rom_data, pc_plus4: pc_q + PC_STEP, valid: 1'b1};
      end
`ifdef IF_STAGE_IRQ_EN
      // Interrupts are taken only in user mode (PC bit 31 clear).
      irq_take_c = irq && !pc_q[XLEN-1];
      epc_d      = epc_q;
      epc_we_d   = irq_take_c;
      if (irq_take_c) begin
         pc_d   = IRQ_VEC;
         ifid_d = IFID_BUBBLE;
         epc_d  = pc_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         ifid_q <= IFID_BUBBLE;
      end else begin
         pc_q   <= pc_d;
         ifid_q <= ifid_d;
      end
   end

`ifdef IF_STAGE_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         epc_q    <= '0;
         epc_we_q <= 1'b0;
      end else begin
         epc_q    <= epc_d;
         epc_we_q <= epc_we_d;
      end
   end

   assign epc    = epc_q;
   assign epc_we = epc_we_q;
`endif

   assign rom_addr      = word_align(pc_q);
   assign ifid_instr    = ifid_q.instr;
   assign ifid_pc_plus4 = ifid_q.pc_plus4;
   assign ifid_valid    = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; instruction memory returns the bitwise inverse of its address.
// Interrupt checks are compiled in when IF_STAGE_IRQ_EN is defined.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [1:0]  pc_sel;
   logic [31:0] branch_target, jump_target, jr_target;
   logic [31:0] rom_addr, rom_data;
   logic [31:0] ifid_instr, ifid_pc_plus4;
   logic        ifid_valid;
`ifdef IF_STAGE_IRQ_EN
   logic        irq;
   logic [31:0] epc;
   logic        epc_we;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign rom_data = ~rom_addr;

   if_stage dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .flush         (flush),
      .pc_sel        (pc_sel),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .jr_target     (jr_target),
`ifdef IF_STAGE_IRQ_EN
      .irq           (irq),
      .epc           (epc),
      .epc_we        (epc_we),
`endif
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus4 (ifid_pc_plus4),
      .ifid_valid    (ifid_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks the full fetch-side state after a cycle.
   task automatic chk_all(input string tag, input logic [31:0] a, input logic v,
                          input logic [31:0] ins, input logic [31:0] p4);
      chk({tag, ".addr"}, rom_addr, a);
      chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
      chk({tag, ".instr"}, ifid_instr, ins);
      chk({tag, ".pc4"}, ifid_pc_plus4, p4);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b1; flush = 1'b1; pc_sel = 2'd2;
      branch_target = 32'h0; jump_target = 32'h1234_5678; jr_target = 32'h0;
`ifdef IF_STAGE_IRQ_EN
      irq = 1'b1;
`endif
      step(); step();
      chk_all("reset", 32'h8000_0000, 1'b0, 32'h0, 32'h0);
`ifdef IF_STAGE_IRQ_EN
      chk("reset.epc", epc, 32'h0);
      chk("reset.epc_we", {31'd0, epc_we}, 32'h0);
      irq = 1'b0;
`endif

      reset = 1'b0; stall = 1'b0; flush = 1'b0; pc_sel = 2'd0;
      chk_all("run0", 32'h8000_0000, 1'b0, 32'h0, 32'h0);
      step(); chk_all("run1", 32'h8000_0004, 1'b1, 32'h7FFF_FFFF, 32'h8000_0004);
      step(); chk_all("run2", 32'h8000_0008, 1'b1, 32'h7FFF_FFFB, 32'h8000_0008);
      step(); chk_all("run3", 32'h8000_000C, 1'b1, 32'h7FFF_FFF7, 32'h8000_000C);

      stall = 1'b1;
      step(); chk_all("stall1", 32'h8000_000C, 1'b1, 32'h7FFF_FFF7, 32'h8000_000C);
      step(); chk_all("stall2", 32'h8000_000C, 1'b1, 32'h7FFF_FFF7, 32'h8000_000C);

      pc_sel = 2'd2; jump_target = 32'h0000_0123;
      step(); chk_all("stall_jump", 32'h8000_0120, 1'b0, 32'h0, 32'h0);

      stall = 1'b0; pc_sel = 2'd0;
      step(); chk_all("after_jump", 32'h8000_0124, 1'b1, 32'h7FFF_FEDF, 32'h8000_0124);

      pc_sel = 2'd1; branch_target = 32'h8000_0018;
      step(); chk_all("branch", 32'h8000_0018, 1'b0, 32'h0, 32'h0);
      pc_sel = 2'd0;
      step(); chk_all("after_branch", 32'h8000_001C, 1'b1, 32'h7FFF_FFE7, 32'h8000_001C);

      flush = 1'b1; stall = 1'b1;
      step(); chk_all("flush_stall", 32'h8000_001C, 1'b0, 32'h0, 32'h0);
      stall = 1'b0;
      step(); chk_all("flush", 32'h8000_0020, 1'b0, 32'h0, 32'h0);
      flush = 1'b0;

      pc_sel = 2'd3; jr_target = 32'hFFFF_FFFE;
      step(); chk_all("jr_top", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
      pc_sel = 2'd0;
      step(); chk_all("wrap", 32'h0000_0000, 1'b1, 32'h0000_0003, 32'h0000_0000);

      pc_sel = 2'd3; jr_target = 32'h0000_0042;
      step(); chk("jr_align", rom_addr, 32'h0000_0040);
      pc_sel = 2'd1; branch_target = 32'h8000_0033;
      step(); chk("branch_keep_user", rom_addr, 32'h0000_0030);
      pc_sel = 2'd2; jump_target = 32'hFFFF_FFFF;
      step(); chk("jump_keep_user", rom_addr, 32'h7FFF_FFFC);

`ifdef IF_STAGE_IRQ_EN
      pc_sel = 2'd3; jr_target = 32'h0000_0010;
      step(); chk("irq_setup", rom_addr, 32'h0000_0010);
      irq = 1'b1; stall = 1'b1; pc_sel = 2'd1; branch_target = 32'h0000_0100;
      step();
      chk_all("irq_take", 32'h8000_0004, 1'b0, 32'h0, 32'h0);
      chk("irq_take.epc", epc, 32'h0000_0010);
      chk("irq_take.epc_we", {31'd0, epc_we}, 32'h1);
      stall = 1'b0; pc_sel = 2'd0;
      step();
      chk("irq_sup.addr", rom_addr, 32'h8000_0008);
      chk("irq_sup.epc_we", {31'd0, epc_we}, 32'h0);
      chk("irq_sup.epc", epc, 32'h0000_0010);
      irq = 1'b0; pc_sel = 2'd3; jr_target = 32'h8000_0010;
      step();
      irq = 1'b1; pc_sel = 2'd0;
      step();
      chk("irq_ign.addr", rom_addr, 32'h8000_0014);
      chk("irq_ign.epc_we", {31'd0, epc_we}, 32'h0);
      irq = 1'b0;
`endif

      reset = 1'b1; pc_sel = 2'd1; branch_target = 32'h0000_0200;
      step(); chk_all("rereset", 32'h8000_0000, 1'b0, 32'h0, 32'h0);
      reset = 1'b0; pc_sel = 2'd0;
      step(); chk_all("rerun", 32'h8000_0004, 1'b1, 32'h7FFF_FFFF, 32'h8000_0004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
